security: RTL and testbench



---
 rtl/security_pkg.sv | 23 ++
 rtl/security_edge_sync.sv | 33 +++
 rtl/security.sv | 108 ++++++++++
 tb/tb_security.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/security_pkg.sv
// Shared types and constants for the lock's failed-attempt supervisor.
//   state_t    : supervisor state (NORMAL / ALARM)
//   MOD3_*     : encodings of the mod-3 comparator result
//   led_therm  : thermometer decode of the attempt count for the warning LEDs
package security_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        ALARM  = 1'b1
    } state_t;

    localparam logic [1:0] MOD3_NONE = 2'b00;
    localparam logic [1:0] MOD3_OK   = 2'b01;
    localparam logic [1:0] MOD3_BAD  = 2'b10;

    function automatic logic [2:0] led_therm(input logic [3:0] count, input logic alarm);
        if (alarm || count >= 4'd3) return 3'b111;
        else if (count == 4'd2)     return 3'b011;
        else if (count == 4'd1)     return 3'b001;
        else                        return 3'b000;
    endfunction

endpackage

// File: rtl/security_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   din   : raw asynchronous level (enter button)
//   pulse : one-cycle pulse per rising edge of din
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            // stage 0/1: metastability filter
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            // stage 2: previous synchronized level and registered edge
            prev_p2 <= sync_p1;
            pulse   <= sync_p1 & ~prev_p2;
        end
    end

endmodule

// File: rtl/security.sv
// Failed-attempt supervisor of the digital lock.
// Counts wrong-code entries, drives warning LEDs and buzzer enable, and enters
// ALARM after ALARM_LIMIT wrong entries. ALARM is left only through a bypass
// request held for BYPASS_HOLD consecutive cycles, which also pulses rst_all.
//   clk, rst_n       : clock, asynchronous active-low reset
//   mode             : 0 = unlock mode (attempts counted), 1 = set-code mode
//   mod3_out         : comparator result (00 none, 01 ok, 10 wrong, 11 ignored)
//   enter            : raw enter button level
//   lock_rst         : synchronous clear of the attempt count (NORMAL only)
//   enb_by_pass_def  : bypass/default request level
//   enb_frequency    : buzzer enable (high in ALARM)
//   led_4            : thermometer warning LEDs
//   rst_all          : one-cycle system reset pulse on bypass exit
//   led_count        : current wrong-attempt count
module security
    import security_pkg::*;
#(
    parameter int ALARM_LIMIT = 3,
    parameter int BYPASS_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic [1:0] mod3_out,
    input  logic       enter,
    input  logic       lock_rst,
    input  logic       enb_by_pass_def,
    output logic       enb_frequency,
    output logic [2:0] led_4,
    output logic       rst_all,
    output logic [3:0] led_count
);

    localparam int              BP_W      = $clog2(BYPASS_HOLD + 1);
    localparam logic [3:0]      LIMIT     = 4'(ALARM_LIMIT);
    localparam logic [BP_W-1:0] HOLD_LAST = BP_W'(BYPASS_HOLD - 1);

    state_t          state, state_nxt;
    logic [3:0]      count, count_nxt;
    logic [BP_W-1:0] bp_cnt, bp_cnt_nxt;
    logic            bp_lock, bp_lock_nxt;
    logic            rst_all_nxt;
    logic            entry;

    edge_sync u_enter_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (enter),
        .pulse (entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= NORMAL;
            count   <= '0;
            bp_cnt  <= '0;
            bp_lock <= 1'b0;
            rst_all <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            bp_cnt  <= bp_cnt_nxt;
            bp_lock <= bp_lock_nxt;
            rst_all <= rst_all_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        bp_cnt_nxt  = '0;
        // after a bypass exit, the request must drop before it can count again
        bp_lock_nxt = bp_lock & enb_by_pass_def;
        rst_all_nxt = 1'b0;
        case (state)
            NORMAL: begin
                if (lock_rst) begin
                    count_nxt = '0;
                end else if (entry && !mode) begin
                    if (mod3_out == MOD3_BAD) begin
                        count_nxt = count + 4'd1;
                        if (count + 4'd1 == LIMIT) state_nxt = ALARM;
                    end else if (mod3_out == MOD3_OK) begin
                        count_nxt = '0;
                    end
                end
            end
            ALARM: begin
                if (enb_by_pass_def && !bp_lock) begin
                    if (bp_cnt == HOLD_LAST) begin
                        state_nxt   = NORMAL;
                        count_nxt   = '0;
                        rst_all_nxt = 1'b1;
                        bp_lock_nxt = 1'b1;
                    end else begin
                        bp_cnt_nxt = bp_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = NORMAL;
        endcase
    end

    assign led_count     = count;
    assign enb_frequency = (state == ALARM);
    assign led_4         = led_therm(count, state == ALARM);

endmodule

// File: tb/tb_security.sv
module tb_security;

    localparam int LIMIT = 3;
    localparam int HOLD  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] mod3_out = 2'b00;
    logic       enter = 1'b0;
    logic       lock_rst = 1'b0;
    logic       enb_by_pass_def = 1'b0;
    logic       enb_frequency;
    logic [2:0] led_4;
    logic       rst_all;
    logic [3:0] led_count;

    security #(.ALARM_LIMIT(LIMIT), .BYPASS_HOLD(HOLD)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mode            (mode),
        .mod3_out        (mod3_out),
        .enter           (enter),
        .lock_rst        (lock_rst),
        .enb_by_pass_def (enb_by_pass_def),
        .enb_frequency   (enb_frequency),
        .led_4           (led_4),
        .rst_all         (rst_all),
        .led_count       (led_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: attempt count, alarm flag, consecutive bypass cycles,
    // and the enter level seen at each past clock edge (index 0 = most recent).
    int m_count;
    bit m_alarm;
    int m_held;
    bit m_wait_release;
    bit m_rst_all;
    bit hist[4];

    function automatic int exp_leds(input int c, input bit a);
        if (a || c >= 3) return 7;
        if (c == 2) return 3;
        if (c == 1) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_count = 0; m_alarm = 0; m_held = 0; m_wait_release = 0; m_rst_all = 0;
        for (int i = 0; i < 4; i++) hist[i] = 0;
    endtask

    task automatic model_step();
        // an entry is a rise of enter first seen three edges ago
        bit ent;
        ent = hist[2] && !hist[3];
        m_rst_all = 0;
        if (!m_alarm) begin
            m_held = 0;
            if (lock_rst) m_count = 0;
            else if (ent && !mode) begin
                if (mod3_out == 2'b10) begin
                    m_count = m_count + 1;
                    if (m_count == LIMIT) m_alarm = 1;
                end else if (mod3_out == 2'b01) begin
                    m_count = 0;
                end
            end
        end else begin
            if (enb_by_pass_def && !m_wait_release) begin
                m_held = m_held + 1;
                if (m_held == HOLD) begin
                    m_alarm = 0; m_count = 0; m_rst_all = 1;
                    m_held = 0; m_wait_release = 1;
                end
            end else begin
                m_held = 0;
            end
        end
        if (!enb_by_pass_def) m_wait_release = 0;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = enter;
    endtask

    task automatic compare_outputs();
        check("led_count", led_count, m_count);
        check("led_4", led_4, exp_leds(m_count, m_alarm));
        check("enb_frequency", enb_frequency, m_alarm);
        check("rst_all", rst_all, m_rst_all);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare_outputs();
    endtask

    task automatic press();
        enter = 1'b1;
        repeat (2) cycle();
        enter = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    int rst_seen;

    initial begin
        model_reset();
        // 1: reset values
        #2;
        compare_outputs();
        check("reset_count", led_count, 0);
        check("reset_led4", led_4, 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();

        // 2: two wrong entries, then lock_rst clear
        mode = 1'b0; mod3_out = 2'b10;
        press(); press();
        check("two_wrong_count", led_count, 2);
        check("two_wrong_led4", led_4, 3'b011);
        check("two_wrong_buzz", enb_frequency, 0);
        lock_rst = 1'b1; cycle(); lock_rst = 1'b0; cycle();
        check("lock_rst_count", led_count, 0);

        // 3: three wrong entries reach alarm, a fourth is ignored
        press(); press(); press();
        check("alarm_count", led_count, 3);
        check("alarm_led4", led_4, 3'b111);
        check("alarm_buzz", enb_frequency, 1);
        press();
        check("alarm_hold_count", led_count, 3);
        lock_rst = 1'b1; cycle(); lock_rst = 1'b0; cycle();
        check("alarm_ignores_lock_rst", led_count, 3);

        // 4: short bypass does nothing, long bypass exits with one rst_all pulse
        enb_by_pass_def = 1'b1;
        repeat (10) cycle();
        enb_by_pass_def = 1'b0;
        cycle();
        check("short_bypass_alarm", enb_frequency, 1);
        enb_by_pass_def = 1'b1;
        rst_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            rst_seen += int'(rst_all);
            if (i == 14) check("bypass_15th_still_alarm", enb_frequency, 1);
            if (i == 15) begin
                check("bypass_exit_buzz", enb_frequency, 0);
                check("bypass_exit_pulse", rst_all, 1);
            end
        end
        check("rst_all_pulses", rst_seen, 1);
        enb_by_pass_def = 1'b0;
        cycle();

        // 5: correct code clears, set-code mode ignores wrong entries
        press(); press();
        mod3_out = 2'b01; press();
        check("ok_clears", led_count, 0);
        mod3_out = 2'b10; press();
        mode = 1'b1; press();
        check("mode1_ignored", led_count, 1);
        mode = 1'b0;
        lock_rst = 1'b1; cycle(); lock_rst = 1'b0;

        // 6: a held button counts once; lock_rst beats a same-cycle entry
        enter = 1'b1;
        repeat (20) cycle();
        enter = 1'b0;
        repeat (4) cycle();
        check("held_counts_once", led_count, 1);
        enter = 1'b1;
        repeat (3) cycle();
        lock_rst = 1'b1;
        cycle();
        lock_rst = 1'b0; enter = 1'b0;
        repeat (4) cycle();
        check("lock_rst_priority", led_count, 0);

        // 7: async reset in the middle of a bypass hold
        press(); press(); press();
        enb_by_pass_def = 1'b1;
        repeat (8) cycle();
        async_reset();
        check("midbypass_reset_buzz", enb_frequency, 0);
        enb_by_pass_def = 1'b0;
        cycle();

        // 8: randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) enter = ~enter;
            if ($urandom_range(0, 24) == 0) enb_by_pass_def = ~enb_by_pass_def;
            mod3_out = ($urandom_range(0, 9) < 6) ? 2'b10 : 2'($urandom_range(0, 3));
            mode     = ($urandom_range(0, 9) == 0);
            lock_rst = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 799) == 0) async_reset();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
